// File: rtl/spi_master_seq_if.sv
// rtl/spi_master_seq_if.sv - SPI pin bundle (spi_if) with master and slave views.
interface spi_if;
  logic sclk;
  logic nss;
  logic mosi;
  logic miso;

  modport master (output sclk, output nss, output mosi, input miso);
  modport slave  (input sclk, input nss, input mosi, output miso);
endinterface

// File: rtl/spi_master_seq.sv
// rtl/spi_master_seq.sv - SPI mode-0 MSB-first master: one nSS window per command, rx bytes as pulses.
// Define SPI_MASTER_SEQ_LOOPBACK_EN to feed the driven MOSI into the rx sampler instead of MISO.
module spi_master_seq #(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic [7:0]       tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  output logic             busy_o,
  spi_if.master            spi
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOAD,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       half_cnt_q, half_cnt_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             smp_q, smp_d;
  logic             sclk_q, sclk_d;
  logic             nss_q, nss_d;
  logic             mosi_q, mosi_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             div_last;
  logic             sample_bit;

`ifdef SPI_MASTER_SEQ_LOOPBACK_EN
  assign sample_bit = mosi_q;
`else
  assign sample_bit = spi.miso;
`endif

  assign div_last = (div_cnt_q == DIV_LAST);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      half_cnt_q <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      smp_q      <= 1'b0;
      sclk_q     <= 1'b0;
      nss_q      <= 1'b1;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      half_cnt_q <= half_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      smp_q      <= smp_d;
      sclk_q     <= sclk_d;
      nss_q      <= nss_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    half_cnt_d = half_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    smp_d      = smp_q;
    sclk_d     = sclk_q;
    nss_d      = nss_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;

    unique case (state_q)
      S_IDLE: begin
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        if (cmd_valid_i) begin
          byte_cnt_d = cmd_len_i;
          nss_d      = 1'b0;
          div_cnt_d  = '0;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (div_last) begin
          div_cnt_d = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        // Without tx data the frame simply stretches here with SCLK parked low.
        if (tx_valid_i) begin
          shreg_d    = tx_data_i;
          mosi_d     = tx_data_i[7];
          div_cnt_d  = '0;
          half_cnt_d = '0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (div_last) begin
          div_cnt_d  = '0;
          half_cnt_d = half_cnt_q + 4'd1;
          sclk_d     = ~sclk_q;
          if (!sclk_q) begin
            smp_d = sample_bit;
          end else begin
            // Falling edge: the sampled bit enters the LSB as the next tx bit leaves the MSB.
            shreg_d = {shreg_q[6:0], smp_q};
            mosi_d  = shreg_q[6];
            if (half_cnt_q == 4'd15) begin
              rx_valid_d = 1'b1;
              rx_data_d  = {shreg_q[6:0], smp_q};
              mosi_d     = 1'b0;
              if (byte_cnt_q == '0) begin
                state_d = S_HOLD;
              end else begin
                byte_cnt_d = byte_cnt_q - LEN_W'(1);
                state_d    = S_LOAD;
              end
            end
          end
        end
      end
      S_HOLD: begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (div_last) begin
          div_cnt_d = '0;
          nss_d     = 1'b1;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (div_last) begin
          div_cnt_d = '0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign tx_ready_o  = (state_q == S_LOAD);
  assign busy_o      = (state_q != S_IDLE);
  assign rx_valid_o  = rx_valid_q;
  assign rx_data_o   = rx_data_q;
  assign spi.sclk    = sclk_q;
  assign spi.nss     = nss_q;
  assign spi.mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_seq.sv
// tb/tb_spi_master_seq.sv - directed bench for spi_master_seq with a mode-0 slave model (CLK_DIV=2).
module tb_spi_master_seq;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [3:0] cmd_len_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       busy_o;

  spi_if ifc ();

  spi_master_seq #(.CLK_DIV(2), .LEN_W(4)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_len_i   (cmd_len_i),
    .tx_data_i   (tx_data_i),
    .tx_valid_i  (tx_valid_i),
    .tx_ready_o  (tx_ready_o),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .busy_o      (busy_o),
    .spi         (ifc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] resp);
`ifdef SPI_MASTER_SEQ_LOOPBACK_EN
    return tx;
`else
    return resp;
`endif
  endfunction

  // Slave model: bit 7 ready at nSS fall, next bit after every SCLK fall.
  logic [7:0] resp_q[$];
  int         s_idx = 0;
  int         s_bit = 0;
  logic       miso_r = 1'b0;

  task automatic slave_drive();
    logic [7:0] cur;
    cur = 8'h00;
    if (s_idx < resp_q.size()) cur = resp_q[s_idx];
    miso_r = cur[7 - s_bit];
  endtask

  always @(negedge ifc.nss) begin
    if (s_bit != 0) s_idx++;
    s_bit = 0;
    slave_drive();
  end

  always @(negedge ifc.sclk) begin
    if (ifc.nss === 1'b0) begin
      s_bit++;
      if (s_bit == 8) begin
        s_idx++;
        s_bit = 0;
      end
      slave_drive();
    end
  end

`ifdef SPI_MASTER_SEQ_LOOPBACK_EN
  assign ifc.miso = 1'b0;
`else
  assign ifc.miso = miso_r;
`endif

  // Pin monitor, sampled on the falling clk edge.
  int          rise_cnt = 0;
  int          low_run = 0;
  int          hi_run = 0;
  int          last_low = 0;
  int          hi_gap = 0;
  logic        sclk_prev = 1'b0;
  logic        nss_prev = 1'b1;
  logic [31:0] mosi_sh = '0;
  logic [7:0]  rx_q[$];

  always @(negedge clk) begin
    if (ifc.sclk === 1'b1 && sclk_prev === 1'b0) begin
      rise_cnt++;
      mosi_sh = {mosi_sh[30:0], ifc.mosi};
    end
    sclk_prev = ifc.sclk;
    if (ifc.nss === 1'b0) begin
      if (nss_prev === 1'b1) hi_gap = hi_run;
      hi_run = 0;
      low_run++;
    end else begin
      if (nss_prev === 1'b0) last_low = low_run;
      low_run = 0;
      hi_run++;
    end
    nss_prev = ifc.nss;
    if (rx_valid_o === 1'b1) rx_q.push_back(rx_data_o);
  end

  logic [7:0] tx_q[$];
  int         stall_bad;
  int         busy_low;

  task automatic run_frames(input int n_cmd, input logic [3:0] len, input int stall_idx);
    int acc, idx, stall;
    bit ch, th, stalling, done;
    acc = 0; idx = 0; stall = 0; stalling = 0; done = 0;
    stall_bad = 0; busy_low = 0;
    @(negedge clk);
    cmd_len_i = len; cmd_valid_i = 1'b1; tx_data_i = tx_q[0]; tx_valid_i = 1'b1;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      ch = cmd_valid_i && cmd_ready_o;
      th = tx_valid_i && tx_ready_o;
      @(posedge clk); #1;
      if (ch) begin
        acc++;
        if (acc == n_cmd) cmd_valid_i = 1'b0;
      end
      if (th) begin
        idx++;
        if (idx == stall_idx) stalling = 1;
      end
      if (stalling && tx_ready_o) begin
        stall++;
        if (ifc.sclk !== 1'b0 || ifc.nss !== 1'b0) stall_bad++;
        if (stall == 11) stalling = 0;
      end
      tx_valid_i = !stalling && (idx < tx_q.size());
      if (idx < tx_q.size()) tx_data_i = tx_q[idx];
      if (acc >= 1 && acc < n_cmd && !busy_o) busy_low++;
      if (acc == n_cmd && !busy_o) done = 1;
    end
    cmd_valid_i = 1'b0;
    tx_valid_i  = 1'b0;
    check_vec("frame_done", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  int rb, r0;
  bit hit;

  initial begin
    reset_i = 1'b1; cmd_valid_i = 1'b0; cmd_len_i = '0; tx_data_i = '0; tx_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_vec("rst_nss",       32'(ifc.nss),     32'd1);
    check_vec("rst_sclk",      32'(ifc.sclk),    32'd0);
    check_vec("rst_mosi",      32'(ifc.mosi),    32'd0);
    check_vec("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check_vec("rst_tx_ready",  32'(tx_ready_o),  32'd0);
    check_vec("rst_rx_valid",  32'(rx_valid_o),  32'd0);
    check_vec("rst_rx_data",   32'(rx_data_o),   32'd0);
    check_vec("rst_busy",      32'(busy_o),      32'd0);
    @(negedge clk) reset_i = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte
    tx_q.delete(); tx_q.push_back(8'hA5); resp_q.push_back(8'h3C);
    rb = rx_q.size(); r0 = rise_cnt;
    run_frames(1, 4'd0, -1);
    check_vec("one_rises",  32'(rise_cnt - r0),      32'd8);
    check_vec("one_mosi",   32'(mosi_sh[7:0]),       32'hA5);
    check_vec("one_rx_cnt", 32'(rx_q.size() - rb),   32'd1);
    check_vec("one_rx",     32'(rx_q[rb]),           32'(exp_rx(8'hA5, 8'h3C)));
    check_vec("one_nss_lo", 32'(last_low),           32'd37);

    // Three-byte frame
    tx_q.delete(); tx_q.push_back(8'h01); tx_q.push_back(8'h02); tx_q.push_back(8'h03);
    resp_q.push_back(8'h11); resp_q.push_back(8'h22); resp_q.push_back(8'h33);
    rb = rx_q.size(); r0 = rise_cnt;
    run_frames(1, 4'd2, -1);
    check_vec("three_rises",  32'(rise_cnt - r0),    32'd24);
    check_vec("three_mosi",   {8'h0, mosi_sh[23:0]}, 32'h010203);
    check_vec("three_rx_cnt", 32'(rx_q.size() - rb), 32'd3);
    check_vec("three_rx0",    32'(rx_q[rb]),         32'(exp_rx(8'h01, 8'h11)));
    check_vec("three_rx1",    32'(rx_q[rb+1]),       32'(exp_rx(8'h02, 8'h22)));
    check_vec("three_rx2",    32'(rx_q[rb+2]),       32'(exp_rx(8'h03, 8'h33)));
    check_vec("three_nss_lo", 32'(last_low),         32'd103);

    // Underflow stretch before byte 2
    tx_q.delete(); tx_q.push_back(8'h81); tx_q.push_back(8'h7E);
    resp_q.push_back(8'hC4); resp_q.push_back(8'h2B);
    rb = rx_q.size(); r0 = rise_cnt;
    run_frames(1, 4'd1, 1);
    check_vec("uf_stall_pins", 32'(stall_bad),         32'd0);
    check_vec("uf_rises",      32'(rise_cnt - r0),     32'd16);
    check_vec("uf_mosi",       {16'h0, mosi_sh[15:0]}, 32'h817E);
    check_vec("uf_rx_cnt",     32'(rx_q.size() - rb),  32'd2);
    check_vec("uf_rx1",        32'(rx_q[rb+1]),        32'(exp_rx(8'h7E, 8'h2B)));
    check_vec("uf_nss_lo",     32'(last_low),          32'd80);

    // Reset mid-byte
    resp_q.push_back(8'h00);
    rb = rx_q.size(); r0 = rise_cnt; hit = 0;
    @(negedge clk);
    cmd_len_i = 4'd0; tx_data_i = 8'hFF; cmd_valid_i = 1'b1; tx_valid_i = 1'b1;
    for (int cyc = 0; cyc < 500 && !hit; cyc++) begin
      @(posedge clk);
      if (busy_o) cmd_valid_i = 1'b0;
      if (rise_cnt - r0 >= 4) hit = 1;
    end
    check_vec("rst_mid_reached", 32'(hit), 32'd1);
    #1 reset_i = 1'b1;
    #1;
    check_vec("rst_mid_nss",  32'(ifc.nss),  32'd1);
    check_vec("rst_mid_sclk", 32'(ifc.sclk), 32'd0);
    check_vec("rst_mid_mosi", 32'(ifc.mosi), 32'd0);
    check_vec("rst_mid_busy", 32'(busy_o),   32'd0);
    cmd_valid_i = 1'b0; tx_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_i = 1'b0;
    @(negedge clk);
    check_vec("rst_mid_ready", 32'(cmd_ready_o), 32'd1);
    repeat (60) @(negedge clk);
    check_vec("rst_mid_no_rx", 32'(rx_q.size() - rb), 32'd0);

    // Back-to-back single-byte commands
    tx_q.delete(); tx_q.push_back(8'h12); tx_q.push_back(8'h34);
    resp_q.push_back(8'h5A); resp_q.push_back(8'hE7);
    rb = rx_q.size(); r0 = rise_cnt;
    run_frames(2, 4'd0, -1);
    check_vec("b2b_rises",    32'(rise_cnt - r0),    32'd16);
    check_vec("b2b_rx_cnt",   32'(rx_q.size() - rb), 32'd2);
    check_vec("b2b_rx0",      32'(rx_q[rb]),         32'(exp_rx(8'h12, 8'h5A)));
    check_vec("b2b_rx1",      32'(rx_q[rb+1]),       32'(exp_rx(8'h34, 8'hE7)));
    check_vec("b2b_nss_gap",  32'(hi_gap),           32'd3);
    check_vec("b2b_busy_low", 32'(busy_low),         32'd1);

    // Loopback pattern (slave byte seen only without loopback)
    tx_q.delete(); tx_q.push_back(8'hC3); resp_q.push_back(8'h96);
    rb = rx_q.size();
    run_frames(1, 4'd0, -1);
    check_vec("lb_rx", 32'(rx_q[rb]), 32'(exp_rx(8'hC3, 8'h96)));

    // Maximum length: cmd_len all ones gives 16 bytes
    tx_q.delete();
    for (int i = 0; i < 16; i++) begin
      tx_q.push_back(8'(i * 17));
      resp_q.push_back(8'(255 - i));
    end
    rb = rx_q.size(); r0 = rise_cnt;
    run_frames(1, 4'hF, -1);
    check_vec("max_rises",  32'(rise_cnt - r0),    32'd128);
    check_vec("max_rx_cnt", 32'(rx_q.size() - rb), 32'd16);
    check_vec("max_rx0",    32'(rx_q[rb]),         32'(exp_rx(8'h00, 8'hFF)));
    check_vec("max_rx15",   32'(rx_q[rb+15]),      32'(exp_rx(8'hFF, 8'hF0)));
    check_vec("max_mosi",   32'(mosi_sh[7:0]),     32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
